// File: rtl/decrypt_pkg.sv
// Shared definitions for the decrypt pipe: ASCII landmarks, word alignment,
// the key FSM state type and the per-character shift amount type.
package decrypt_pkg;

  localparam int ASCII_UPPER_A = 65;
  localparam int ASCII_LOWER_A = 97;
  localparam int ALPHA_COUNT   = 26;
  localparam int EXT_ALIGN     = 6;

  typedef enum logic {
    NOKEY = 1'b0,
    KEYED = 1'b1
  } key_state_e;

  typedef logic [2:0] shift_amt_t;

  // A digit of 7 would rotate a full alphabet step too far downstream; use 6.
  function automatic shift_amt_t clamp_digit(input logic [2:0] raw);
    return (raw == 3'd7) ? shift_amt_t'(3'd6) : shift_amt_t'(raw);
  endfunction

endpackage

// File: rtl/key_sched.sv
// Key schedule: stores the clamped multi-digit key, flags bad digits, and
// walks a wrapping pointer to select the digit for each ciphered letter.
module key_sched
  import decrypt_pkg::*;
#(
  parameter int KEY_DIGITS = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    key_load,
  input  logic [3*KEY_DIGITS-1:0] key_in,
  input  logic                    advance,
  output logic                    keyed_eff,
  output shift_amt_t              digit,
  output logic                    key_err
);

  localparam int PTR_W = (KEY_DIGITS > 1) ? $clog2(KEY_DIGITS) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(KEY_DIGITS - 1);

  key_state_e                       state_q, state_d;
  logic       [PTR_W-1:0]           ptr_q, ptr_d, ptr_base;
  logic       [KEY_DIGITS-1:0][2:0] key_q, key_clamped;
  logic                             any_seven;

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    any_seven   = 1'b0;
    key_clamped = '0;
    for (int k = 0; k < KEY_DIGITS; k++) begin
      key_clamped[k] = clamp_digit(key_in[3*k +: 3]);
      if (key_in[3*k +: 3] == 3'd7) any_seven = 1'b1;
    end
  end

  // A load in the same cycle as a byte applies to that byte.
  assign keyed_eff = key_load || (state_q == KEYED);

  always_comb begin
    state_d  = state_q;
    ptr_base = key_load ? '0 : ptr_q;
    ptr_d    = ptr_base;
    digit    = '0;
    if (key_load) state_d = KEYED;
    if (key_load)
      digit = key_clamped[0];
    else if (state_q == KEYED)
      digit = key_q[ptr_q];
    if (advance && keyed_eff)
      ptr_d = (ptr_base == PTR_LAST) ? '0 : ptr_base + 1'b1;
  end

  // NOTE: the key store is reset along with the control state, so no stale key
  // survives a mid-stream reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= NOKEY;
      ptr_q   <= '0;
      key_q   <= '0;
      key_err <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      state_q <= state_d;
      ptr_q   <= ptr_d;
      if (key_load) begin
        key_q   <= key_clamped;
        key_err <= any_seven;
      end
    end
  end

endmodule

// File: rtl/decrypt_pipe_extend.sv
// First decrypt pipe stage: classifies each byte, encodes letters one-hot into
// the 32-bit extended word, and registers everything with the key digit.
module decrypt_pipe_extend
  import decrypt_pkg::*;
#(
  parameter int KEY_DIGITS = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en_in,
  input  logic                    mode_in,
  input  logic                    shift_en_in,
  input  logic [7:0]              data_in,
  input  logic                    key_load,
  input  logic [3*KEY_DIGITS-1:0] key_in,
  output logic                    en,
  output logic                    mode,
  output logic                    shift_en,
  output shift_amt_t              shift_amt,
  output logic [31:0]             extended_shift_out,
  output logic                    is_alpha_upper_case,
  output logic                    is_alpha_low_case,
  output logic                    key_err
);

  logic       is_upper, is_lower, is_alpha, keyed_eff;
  logic [4:0] letter_idx;
  logic [31:0] ext_word;
  shift_amt_t digit;

  always_comb begin
    is_upper   = (data_in >= 8'(ASCII_UPPER_A)) &&
                 (data_in <= 8'(ASCII_UPPER_A + ALPHA_COUNT - 1));
    is_lower   = (data_in >= 8'(ASCII_LOWER_A)) &&
                 (data_in <= 8'(ASCII_LOWER_A + ALPHA_COUNT - 1));
    is_alpha   = is_upper || is_lower;
    letter_idx = '0;
    if (is_upper)
      letter_idx = 5'(data_in - 8'(ASCII_UPPER_A));
    else if (is_lower)
      letter_idx = 5'(data_in - 8'(ASCII_LOWER_A));
    // Letters sit above a 6-bit guard band so the shift stage can rotate down.
    ext_word = is_alpha ? (32'h1 << (letter_idx + 5'(EXT_ALIGN))) : {24'b0, data_in};
  end

  key_sched #(
    .KEY_DIGITS(KEY_DIGITS)
  ) u_key_sched (
    .clk      (clk),
    .rst      (rst),
    .key_load (key_load),
    .key_in   (key_in),
    .advance  (en_in && mode_in && shift_en_in && is_alpha),
    .keyed_eff(keyed_eff),
    .digit    (digit),
    .key_err  (key_err)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en                  <= 1'b0;
      mode                <= 1'b0;
      shift_en            <= 1'b0;
      shift_amt           <= '0;
      extended_shift_out  <= '0;
      is_alpha_upper_case <= 1'b0;
      is_alpha_low_case   <= 1'b0;
    end else begin
      en                  <= en_in;
      mode                <= mode_in;
      shift_en            <= shift_en_in && keyed_eff;
      shift_amt           <= digit;
      extended_shift_out  <= ext_word;
      is_alpha_upper_case <= is_upper;
      is_alpha_low_case   <= is_lower;
    end
  end

endmodule
